// File: rtl/uart_sample_rx_if.sv
// Bundles the UART line and the decoded per-channel sample outputs of uart_sample_rx.
// The receiver takes the slave modport; whoever drives rx and consumes samples takes master.
interface uart_sample_rx_if #(
  parameter int W = 16
);
  logic                rx;
  logic signed [W-1:0] sample_out0;
  logic signed [W-1:0] sample_out1;
  logic signed [W-1:0] sample_out2;
  logic signed [W-1:0] sample_out3;
  logic                sample_strobe;
  logic [1:0]          sample_ch;
  logic                rx_busy;
  logic [7:0]          err_count;

  modport master (
    output rx,
    input  sample_out0, sample_out1, sample_out2, sample_out3,
    input  sample_strobe, sample_ch, rx_busy, err_count
  );

  modport slave (
    input  rx,
    output sample_out0, sample_out1, sample_out2, sample_out3,
    output sample_strobe, sample_ch, rx_busy, err_count
  );
endinterface

// File: rtl/uart_sample_rx.sv
// 8N1 UART receiver plus 'C','H',ch,MSB,LSB frame parser holding the last sample per channel.
// Update lands 1 clk after the LSB byte_valid; no backpressure, bytes are consumed as they arrive.
module uart_sample_rx #(
  parameter int W            = 16,
  parameter int CLK_FREQ     = 12_000_000,
  parameter int BAUD_RATE    = 1_000_000,
  parameter int TIMEOUT_CLKS = 1200
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_sample_rx_if.slave   bus
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);
  localparam int TW  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);

  if (CPB < 4 || W != 16) begin : g_param_err
    $error("uart_sample_rx: need CLK_FREQ/BAUD_RATE >= 4 and W == 16");
  end

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} r_state_e;
  typedef enum logic [2:0] {P_C, P_H, P_CH, P_MSB, P_LSB} p_state_e;

  r_state_e            r_state_q;
  p_state_e            p_state_q;
  logic [1:0]          sync_q;
  logic [CW-1:0]       cnt_q;
  logic [2:0]          bit_q;
  logic [7:0]          shift_q;
  logic                byte_vld_q;
  logic                rx_busy_q;
  logic [TW-1:0]       idle_q;
  logic [7:0]          err_q;
  logic [1:0]          ch_q;
  logic [7:0]          msb_q;
  logic signed [W-1:0] sample_q [4];
  logic                strobe_q;
  logic [1:0]          sample_ch_q;

  logic rx_s;
  logic frame_err;
  logic timeout;

  assign rx_s      = sync_q[1];
  assign frame_err = (r_state_q == R_STOP) && (cnt_q == LAST) && !rx_s;
  // A byte arriving on the very cycle the idle limit is hit keeps the frame alive.
  assign timeout   = (p_state_q != P_C) && (idle_q == TW'(TIMEOUT_CLKS - 1)) && !byte_vld_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q     <= 2'b11;
      r_state_q  <= R_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_vld_q <= 1'b0;
      rx_busy_q  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], bus.rx};
      byte_vld_q <= 1'b0;
      case (r_state_q)
        R_IDLE: begin
          if (!rx_s) begin
            r_state_q <= R_START;
            cnt_q     <= '0;
            rx_busy_q <= 1'b1;
          end
        end
        R_START: begin
          if (cnt_q == HALF) begin
            cnt_q <= '0;
            bit_q <= '0;
            if (!rx_s) begin
              r_state_q <= R_DATA;
            end else begin
              r_state_q <= R_IDLE;
              rx_busy_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        R_DATA: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) r_state_q <= R_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        R_STOP: begin
          if (cnt_q == LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              byte_vld_q <= 1'b1;
              r_state_q  <= R_IDLE;
              rx_busy_q  <= 1'b0;
            end else begin
              r_state_q <= R_WAIT;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        R_WAIT: begin
          if (rx_s) begin
            r_state_q <= R_IDLE;
            rx_busy_q <= 1'b0;
          end
        end
        default: begin
          r_state_q <= R_IDLE;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_state_q   <= P_C;
      idle_q      <= '0;
      err_q       <= '0;
      ch_q        <= '0;
      msb_q       <= '0;
      strobe_q    <= 1'b0;
      sample_ch_q <= '0;
      for (int i = 0; i < 4; i++) sample_q[i] <= '0;
    end else begin
      strobe_q <= 1'b0;
      if (byte_vld_q || p_state_q == P_C) idle_q <= '0;
      else                                idle_q <= idle_q + 1'b1;

      // Framing error and timeout together still count as a single error.
      if ((frame_err || timeout) && err_q != 8'hFF) err_q <= err_q + 1'b1;

      if (frame_err || timeout) begin
        p_state_q <= P_C;
      end else if (byte_vld_q) begin
        case (p_state_q)
          P_C: if (shift_q == 8'h43) p_state_q <= P_H;
          P_H: begin
            if      (shift_q == 8'h48) p_state_q <= P_CH;
            else if (shift_q == 8'h43) p_state_q <= P_H;
            else                       p_state_q <= P_C;
          end
          P_CH: begin
            if (shift_q[7:2] == 6'b001100) begin
              ch_q      <= shift_q[1:0];
              p_state_q <= P_MSB;
            end else if (shift_q == 8'h43) begin
              p_state_q <= P_H;
            end else begin
              p_state_q <= P_C;
            end
          end
          P_MSB: begin
            msb_q     <= shift_q;
            p_state_q <= P_LSB;
          end
          P_LSB: begin
            sample_q[ch_q] <= $signed({msb_q, shift_q});
            sample_ch_q    <= ch_q;
            strobe_q       <= 1'b1;
            p_state_q      <= P_C;
          end
          default: p_state_q <= P_C;
        endcase
      end
    end
  end

  assign bus.sample_out0   = sample_q[0];
  assign bus.sample_out1   = sample_q[1];
  assign bus.sample_out2   = sample_q[2];
  assign bus.sample_out3   = sample_q[3];
  assign bus.sample_strobe = strobe_q;
  assign bus.sample_ch     = sample_ch_q;
  assign bus.rx_busy       = rx_busy_q;
  assign bus.err_count     = err_q;
endmodule

// File: tb/tb_uart_sample_rx.sv
// Directed bench for uart_sample_rx: drives 8N1 bytes at 12 clk/bit and checks decoded samples.
module tb_uart_sample_rx;
  localparam int W   = 16;
  localparam int CPB = 12;
  localparam int GAP = 4;

  logic clk = 1'b0;
  logic rst_n;

  uart_sample_rx_if #(.W(W)) bus();

  uart_sample_rx #(
    .W(W), .CLK_FREQ(12_000_000), .BAUD_RATE(1_000_000), .TIMEOUT_CLKS(1200)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  int strobe_cnt = 0;
  int busy_rise  = 0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.sample_strobe === 1'b1) strobe_cnt++;
    if (bus.rx_busy === 1'b1 && !busy_prev) busy_rise++;
    busy_prev = (bus.rx_busy === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3);
    check({tag, "_out0"}, {16'd0, bus.sample_out0}, {16'd0, e0});
    check({tag, "_out1"}, {16'd0, bus.sample_out1}, {16'd0, e1});
    check({tag, "_out2"}, {16'd0, bus.sample_out2}, {16'd0, e2});
    check({tag, "_out3"}, {16'd0, bus.sample_out3}, {16'd0, e3});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bus.rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      tick(CPB);
    end
    bus.rx = stop;
    tick(CPB);
    bus.rx = 1'b1;
    tick(GAP);
  endtask

  task automatic send5(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
    send_byte(b4, 1'b1);
    tick(20);
  endtask

  int s0;
  int b0;

  initial begin
    rst_n  = 1'b0;
    bus.rx = 1'b1;
    tick(5);
    check_outs("reset", 16'h0, 16'h0, 16'h0, 16'h0);
    check("reset_strobe", {31'd0, bus.sample_strobe}, 32'd0);
    check("reset_ch",     {30'd0, bus.sample_ch}, 32'd0);
    check("reset_busy",   {31'd0, bus.rx_busy}, 32'd0);
    check("reset_err",    {24'd0, bus.err_count}, 32'd0);
    rst_n = 1'b1;
    tick(10);

    // Basic frame on channel 2.
    s0 = strobe_cnt;
    send5(8'h43, 8'h48, 8'h32, 8'h12, 8'h34);
    check_outs("ch2", 16'h0, 16'h0, 16'h1234, 16'h0);
    check("ch2_strobes", strobe_cnt - s0, 32'd1);
    check("ch2_ch",  {30'd0, bus.sample_ch}, 32'd2);
    check("ch2_err", {24'd0, bus.err_count}, 32'd0);

    // Negative value, then data bytes equal to 'C'/'H'.
    send5(8'h43, 8'h48, 8'h30, 8'h80, 8'h01);
    check("ch0_neg", 32'(bus.sample_out0), 32'hFFFF8001);
    send5(8'h43, 8'h48, 8'h30, 8'h43, 8'h48);
    check_outs("ch0_ch", 16'h4348, 16'h0, 16'h1234, 16'h0);
    check("ch0_ch_sel", {30'd0, bus.sample_ch}, 32'd0);

    // Resync on a doubled 'C'.
    s0 = strobe_cnt;
    send_byte(8'h43, 1'b1);
    send5(8'h43, 8'h48, 8'h31, 8'h00, 8'h05);
    check_outs("resync", 16'h4348, 16'h0005, 16'h1234, 16'h0);
    check("resync_strobes", strobe_cnt - s0, 32'd1);
    check("resync_ch", {30'd0, bus.sample_ch}, 32'd1);

    // Bad channel ignored, following frame on ch3 accepted.
    s0 = strobe_cnt;
    send5(8'h43, 8'h48, 8'h34, 8'hAA, 8'hBB);
    check("badch_strobes", strobe_cnt - s0, 32'd0);
    check_outs("badch", 16'h4348, 16'h0005, 16'h1234, 16'h0);
    send5(8'h43, 8'h48, 8'h33, 8'h7F, 8'hFE);
    check_outs("ch3", 16'h4348, 16'h0005, 16'h1234, 16'h7FFE);
    check("ch3_ch", {30'd0, bus.sample_ch}, 32'd3);

    // Short low glitch: busy pulse only.
    s0 = strobe_cnt;
    b0 = busy_rise;
    bus.rx = 1'b0;
    tick(3);
    bus.rx = 1'b1;
    tick(30);
    check("glitch_busy_pulse", busy_rise - b0, 32'd1);
    check("glitch_busy_now", {31'd0, bus.rx_busy}, 32'd0);
    check("glitch_strobes", strobe_cnt - s0, 32'd0);
    check("glitch_err", {24'd0, bus.err_count}, 32'd0);

    // Framing error while parser waits for MSB, then recovery.
    s0 = strobe_cnt;
    send_byte(8'h43, 1'b1);
    send_byte(8'h48, 1'b1);
    send_byte(8'h31, 1'b1);
    send_byte(8'h55, 1'b0);
    tick(20);
    check("ferr_err", {24'd0, bus.err_count}, 32'd1);
    check("ferr_strobes", strobe_cnt - s0, 32'd0);
    send5(8'h43, 8'h48, 8'h31, 8'h12, 8'h21);
    check_outs("ferr_recover", 16'h4348, 16'h1221, 16'h1234, 16'h7FFE);

    // Gap just under the idle limit is tolerated.
    send_byte(8'h43, 1'b1);
    send_byte(8'h48, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h11, 1'b1);
    tick(1000);
    send_byte(8'h22, 1'b1);
    tick(20);
    check("slow_out3", {16'd0, bus.sample_out3}, 32'h1122);
    check("slow_err", {24'd0, bus.err_count}, 32'd1);

    // Gap beyond the idle limit aborts the frame.
    s0 = strobe_cnt;
    send_byte(8'h43, 1'b1);
    send_byte(8'h48, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h11, 1'b1);
    tick(1300);
    send_byte(8'h22, 1'b1);
    tick(20);
    check("tmo_strobes", strobe_cnt - s0, 32'd0);
    check("tmo_out3", {16'd0, bus.sample_out3}, 32'h1122);
    check("tmo_err", {24'd0, bus.err_count}, 32'd2);

    // Reset in the middle of a byte.
    bus.rx = 1'b0;
    tick(30);
    rst_n  = 1'b0;
    bus.rx = 1'b1;
    tick(1);
    rst_n = 1'b1;
    check_outs("midrst", 16'h0, 16'h0, 16'h0, 16'h0);
    check("midrst_err",  {24'd0, bus.err_count}, 32'd0);
    check("midrst_busy", {31'd0, bus.rx_busy}, 32'd0);
    check("midrst_ch",   {30'd0, bus.sample_ch}, 32'd0);
    tick(30);
    s0 = strobe_cnt;
    send5(8'h43, 8'h48, 8'h32, 8'hBE, 8'hEF);
    check_outs("postrst", 16'h0, 16'h0, 16'hBEEF, 16'h0);
    check("postrst_strobes", strobe_cnt - s0, 32'd1);

    // Saturation of the error counter.
    for (int i = 0; i < 254; i++) send_byte(8'h00, 1'b0);
    tick(20);
    check("err_254", {24'd0, bus.err_count}, 32'd254);
    for (int i = 0; i < 46; i++) send_byte(8'h00, 1'b0);
    tick(20);
    check("err_sat", {24'd0, bus.err_count}, 32'd255);
    check_outs("sat_keep", 16'h0, 16'h0, 16'hBEEF, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
